// File: rtl/seven_seg_if.sv
// Display-side signal bundle for the 8-digit multiplexed 7-segment driver.
// master = upstream latch stage / bench, slave = scan driver.
interface seven_seg_if;
   logic [31:0] disp_num;
   logic [7:0]  dp_en;
   logic [7:0]  blink_mask;
   logic        lz_blank;
   logic [7:0]  anode;
   logic [7:0]  segment;
   logic        frame_done;

   modport master (
      output disp_num, dp_en, blink_mask, lz_blank,
      input  anode, segment, frame_done
   );

   modport slave (
      input  disp_num, dp_en, blink_mask, lz_blank,
      output anode, segment, frame_done
   );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode 7-segment driver: per-frame snapshot, hex decode,
// dead time between slots, leading-zero blanking, per-digit decimal point and blink.
module seven_seg_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD_CYC     = 16,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       reset,
   seven_seg_if.slave disp
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
   localparam logic [31:0]      DEAD_U    = 32'(DEAD_CYC);

   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       idx;
   logic [31:0]      shadow;
   logic [FRM_W-1:0] frame_cnt;
   logic             blink_ph;

   logic             tick;
   logic             frame_wrap;
   logic             dead;
   logic             blank;
   logic [3:0]       nib;
   logic [31:0]      upper;
   logic [7:0]       anode_nxt;
   logic [7:0]       segment_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      tick        = (div_cnt == DIV_LAST);
      frame_wrap  = tick && (idx == 3'd7);
      dead        = (32'(div_cnt) < DEAD_U);
      nib         = shadow[{idx, 2'b00} +: 4];
      // Everything at and above the current nibble; zero means a leading zero.
      upper       = shadow >> {idx, 2'b00};
      blank       = (disp.blink_mask[idx] && blink_ph) ||
                    (disp.lz_blank && (idx != 3'd0) && (upper == 32'd0));
      anode_nxt   = 8'hFF;
      segment_nxt = 8'hFF;
      if (!dead && !blank) begin
         anode_nxt   = ~(8'b1 << idx);
         segment_nxt = {~disp.dp_en[idx], hex7(nib)};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt         <= '0;
         idx             <= 3'd0;
         shadow          <= 32'd0;
         frame_cnt       <= '0;
         blink_ph        <= 1'b0;
         disp.anode      <= 8'hFF;
         disp.segment    <= 8'hFF;
         disp.frame_done <= 1'b0;
      end else begin
         if (tick) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         // Latch once per frame so a mid-frame update never tears the display.
         if ((div_cnt == '0) && (idx == 3'd0))
            shadow <= disp.disp_num;

         if (frame_wrap) begin
            if (frame_cnt == FRM_LAST) begin
               frame_cnt <= '0;
               blink_ph  <= ~blink_ph;
            end else begin
               frame_cnt <= frame_cnt + FRM_W'(1);
            end
         end

         disp.frame_done <= frame_wrap;
         disp.anode      <= anode_nxt;
         disp.segment    <= segment_nxt;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with a 4-cycle slot, 1-cycle dead time, 2-frame blink.
module tb_seven_seg_scan;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seven_seg_if dif ();

   seven_seg_scan #(
      .SCAN_DIV    (4),
      .DEAD_CYC    (1),
      .BLINK_FRAMES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .disp (dif.slave)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int fd_cnt = 0;
   int multi_low = 0;
   int fd0;

   // 12345678 and 0123ABCD decoded per digit (digit 0 first), dp off.
   logic [7:0] seg_a [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
   logic [7:0] seg_b [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (dif.frame_done === 1'b1) fd_cnt++;
         if ($countones(~dif.anode) > 1) multi_low++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   // Advance to 1 time unit after the n-th posedge since reset release.
   task automatic run_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic chk_dig(input string tag, input int n, input logic [7:0] an,
                          input logic [7:0] sg);
      run_to(n);
      chk($sformatf("%s_anode_n%0d", tag, n), {24'd0, dif.anode}, {24'd0, an});
      chk($sformatf("%s_seg_n%0d", tag, n), {24'd0, dif.segment}, {24'd0, sg});
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      reset          = 1'b0;
      dif.disp_num   = 32'h12345678;
      dif.dp_en      = 8'h00;
      dif.blink_mask = 8'h00;
      dif.lz_blank   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_anode", {24'd0, dif.anode}, 32'hFF);
      chk("rst_seg", {24'd0, dif.segment}, 32'hFF);
      chk("rst_fd", {31'd0, dif.frame_done}, 32'd0);
      release_reset();

      // Frame 0: snapshot of 12345678; disp_num change at n=2 must not show.
      chk_dig("f0_dead0", 1, 8'hFF, 8'hFF);
      chk_dig("f0_first", 2, 8'hFE, seg_a[0]);
      dif.disp_num = 32'h0123ABCD;
      for (int d = 0; d < 8; d++) begin
         if (d > 0) chk_dig($sformatf("f0_dead%0d", d), 4*d + 1, 8'hFF, 8'hFF);
         chk_dig($sformatf("f0_dig%0d", d), 4*d + 3, ~(8'd1 << d), seg_a[d]);
      end
      run_to(31);
      chk("fd_n31", {31'd0, dif.frame_done}, 32'd0);
      run_to(32);
      chk("fd_n32", {31'd0, dif.frame_done}, 32'd1);
      run_to(33);
      chk("fd_n33", {31'd0, dif.frame_done}, 32'd0);

      // Frame 1: 0123ABCD.
      for (int d = 0; d < 8; d++)
         chk_dig($sformatf("f1_dig%0d", d), 32 + 4*d + 3, ~(8'd1 << d), seg_b[d]);

      // Frame 2: change during digit 3; upper digits keep the old snapshot.
      run_to(66);
      fd0 = fd_cnt;
      for (int d = 0; d < 8; d++) begin
         chk_dig($sformatf("f2_dig%0d", d), 64 + 4*d + 3, ~(8'd1 << d), seg_b[d]);
         if (d == 3) dif.disp_num = 32'hFFFFFFFF;
      end

      // Frame 3: all F.
      for (int d = 0; d < 8; d++)
         chk_dig($sformatf("f3_dig%0d", d), 96 + 4*d + 3, ~(8'd1 << d), 8'h8E);
      dif.lz_blank = 1'b1;
      dif.disp_num = 32'h00000050;
      run_to(130);
      chk("fd_count_2frames", fd_cnt - fd0, 32'd2);

      // Frame 4: leading zeros blanked, digit 0 zero still shown.
      chk_dig("lz_dig0", 131, 8'hFE, 8'hC0);
      chk_dig("lz_dig1", 135, 8'hFD, 8'h92);
      for (int d = 2; d < 8; d++)
         chk_dig($sformatf("lz_dig%0d", d), 128 + 4*d + 3, 8'hFF, 8'hFF);
      dif.disp_num = 32'h00000000;

      // Frame 5: value 0 -> only digit 0.
      chk_dig("lz0_dig0", 163, 8'hFE, 8'hC0);
      chk_dig("lz0_dig1", 167, 8'hFF, 8'hFF);
      chk_dig("lz0_dig2", 171, 8'hFF, 8'hFF);
      dif.lz_blank = 1'b0;
      chk_dig("nolz_dig5", 182, 8'hDF, 8'hC0);

      // Async reset in the middle of the digit-5 slot.
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_anode", {24'd0, dif.anode}, 32'hFF);
      chk("mid_rst_seg", {24'd0, dif.segment}, 32'hFF);
      chk("mid_rst_fd", {31'd0, dif.frame_done}, 32'd0);
      dif.disp_num   = 32'h00000007;
      dif.dp_en      = 8'h01;
      dif.blink_mask = 8'h01;
      repeat (2) @(posedge clk);
      #1;
      chk("held_rst_anode", {24'd0, dif.anode}, 32'hFF);
      release_reset();

      // Restart at digit 0 with fresh snapshot; blink on digit 0 every 2 frames.
      chk_dig("rs_dead0", 1, 8'hFF, 8'hFF);
      chk_dig("bl_f0_dig0", 3, 8'hFE, 8'h78);
      chk_dig("bl_f0_dig1", 7, 8'hFD, 8'hC0);
      chk_dig("bl_f1_dig0", 35, 8'hFE, 8'h78);
      chk_dig("bl_f2_dig0", 67, 8'hFF, 8'hFF);
      chk_dig("bl_f2_dig1", 71, 8'hFD, 8'hC0);
      chk_dig("bl_f3_dig0", 99, 8'hFF, 8'hFF);
      chk_dig("bl_f4_dig0", 131, 8'hFE, 8'h78);

      chk("multi_anode_low", multi_low, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
